// File: rtl/lfsr_bank.sv
// Multi-channel Fibonacci LFSR bank behind an MMIO register file. Each channel holds
// POLY, DATA (Q), CTRL and COUNT registers; read data returns one cycle after the strobe.
module lfsr_bank #(
  parameter int          N        = 32,
  parameter int          CHANNELS = 4,
  parameter logic [15:0] BASE     = 16'h0010
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                W,
  input  logic [15:0]         A,
  input  logic [63:0]         D,
  input  logic                R,
  input  logic [15:0]         RA,
  output logic [63:0]         RD,
  output logic                RV,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] done
);

  // The per-channel FSM state is the CTRL register itself, so software reads it back directly.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_STEP  = 2'b01,
    ST_RUN   = 2'b10,
    ST_BURST = 2'b11
  } state_e;

  localparam logic [15:0] STATUS_ADDR = BASE + 16'(8 * CHANNELS);

  logic [N-1:0]        poly_all  [CHANNELS];
  logic [N-1:0]        q_all     [CHANNELS];
  logic [31:0]         count_all [CHANNELS];
  state_e              state_all [CHANNELS];
  logic [CHANNELS-1:0] lock_all;
  logic                wr_status;
  logic [63:0]         rd_d, rd_q;
  logic                rv_q;
  logic                unused_bits;

  assign wr_status   = W && (A == STATUS_ADDR);
  assign unused_bits = ^D;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    localparam logic [15:0] CH_BASE = BASE + 16'(8 * g);

    logic         wr_poly, wr_data, wr_ctrl, wr_count;
    logic         shift, advance;
    logic [N-1:0] poly_q, poly_d, q_q, q_d;
    logic [31:0]  count_q, count_d;
    state_e       state_q, state_d;
    logic         done_q, done_d, lock_q, lock_d;

    assign wr_poly  = W && (A == CH_BASE);
    assign wr_data  = W && (A == CH_BASE + 16'd2);
    assign wr_ctrl  = W && (A == CH_BASE + 16'd4);
    assign wr_count = W && (A == CH_BASE + 16'd6);

    always_comb begin
      poly_d  = poly_q;
      q_d     = q_q;
      count_d = count_q;
      state_d = state_q;
      done_d  = 1'b0;
      shift   = 1'b0;
      case (state_q)
        ST_STEP: begin
          shift   = 1'b1;
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
        ST_RUN:  shift = 1'b1;
        ST_BURST: begin
          if (count_q == 32'd0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            shift = 1'b1;
          end
        end
        default: ;
      endcase
      // A DATA write steals the cycle: no shift, and so no burst decrement either.
      advance = shift && !wr_data;
      if (wr_data) q_d = D[N-1:0];
      else if (advance) q_d = {q_q[N-2:0], ^(q_q & poly_q)};
      if (state_q == ST_BURST && advance && !wr_count) begin
        count_d = count_q - 32'd1;
        if (count_q == 32'd1) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      if (wr_count) count_d = D[31:0];
      if (wr_poly)  poly_d  = D[N-1:0];
      if (wr_ctrl)  state_d = state_e'(D[1:0]);
      lock_d = ((state_q != ST_IDLE) && (q_q == '0)) || (lock_q && !(wr_status && D[g]));
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        poly_q  <= '0;
        q_q     <= '0;
        count_q <= '0;
        state_q <= ST_IDLE;
        done_q  <= 1'b0;
        lock_q  <= 1'b0;
      end else begin
        poly_q  <= poly_d;
        q_q     <= q_d;
        count_q <= count_d;
        state_q <= state_d;
        done_q  <= done_d;
        lock_q  <= lock_d;
      end
    end

    assign poly_all[g]  = poly_q;
    assign q_all[g]     = q_q;
    assign count_all[g] = count_q;
    assign state_all[g] = state_q;
    assign lock_all[g]  = lock_q;
    assign busy[g]      = (state_q != ST_IDLE);
    assign done[g]      = done_q;
  end

  // Read mux samples the pre-update register values of the strobe cycle.
  always_comb begin
    rd_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (RA == BASE + 16'(8 * c))     rd_d = 64'(poly_all[c]);
      if (RA == BASE + 16'(8 * c + 2)) rd_d = 64'(q_all[c]);
      if (RA == BASE + 16'(8 * c + 4)) rd_d = 64'(state_all[c]);
      if (RA == BASE + 16'(8 * c + 6)) rd_d = 64'(count_all[c]);
    end
    if (RA == STATUS_ADDR) rd_d = 64'(lock_all);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_q <= '0;
      rv_q <= 1'b0;
    end else begin
      rv_q <= R;
      if (R) rd_q <= rd_d;
    end
  end

  assign RD = rd_q;
  assign RV = rv_q;

endmodule

// File: doc/lfsr_bank.md
Name: lfsr_bank

Overview:
Multi-channel, width-parametrised LFSR application unit for the CCI-P AFU. It sits behind the AFU MMIO decode and owns its own register file, with per-channel polynomial, state, control and burst count. The AFU shell forwards MMIO writes and reads; the unit returns read data with a fixed one-cycle latency. Over the single-LFSR generation it adds channel count, burst mode, auto-return step mode, lockup detection and done pulses.

Parameters:
N, 32, LFSR width in bits (2..64)
CHANNELS, 4, number of independent LFSR channels (1..8)
BASE, 16'h0010, dword address of channel 0 register block

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
W  in  1  MMIO write strobe, one cycle per write
A  in  16  MMIO write dword address
D  in  64  MMIO write data; low N bits used for POLY/DATA
R  in  1  MMIO read strobe
RA  in  16  MMIO read dword address
RD  out  64  read data, zero-extended
RV  out  1  read data valid
busy  out  CHANNELS  channel c is shifting (mode != stop)
done  out  CHANNELS  one-cycle pulse when a step or burst completes

Behaviour:
- Register map, channel c, block at BASE+8*c: +0 POLY, +2 DATA (Q), +4 CTRL[1:0], +6 COUNT[31:0]. STATUS at BASE+8*CHANNELS holds LOCK[CHANNELS-1:0].
- The unit decodes all other addresses: reads return 0, writes are ignored.
- Reset (reset=0, async) clears every POLY, Q, CTRL, COUNT, LOCK, RD, RV, busy and done to 0.
- Shift rule (Fibonacci, left): Q <= {Q[N-2:0], ^(Q & POLY)}. One shift per cycle per active channel.
- CTRL modes:
  - 00 = STOP.
  - 01 = STEP: exactly one shift on the next cycle, then CTRL auto-clears to 00 and done[c] pulses in the same cycle as the shift.
  - 10 = CONT: shift every cycle until software writes CTRL.
  - 11 = BURST: shift while COUNT!=0, with COUNT decrementing on each shift. On the shift that takes COUNT from 1 to 0, CTRL clears to 00 and done[c] pulses. BURST entered with COUNT=0 returns to 00 the next cycle with no shift and pulses done.
- Per-channel FSM: IDLE(00), STEP, RUN, BURST. Transitions are taken only on CTRL writes or on auto-completion.
- busy[c] = (CTRL!=00), registered with CTRL.
- Simultaneous events:
  - A DATA write in the same cycle as a shift wins: Q takes the written value and no shift occurs that cycle.
  - A COUNT write during BURST replaces the remaining count; the decrement is dropped that cycle.
  - A CTRL write overrides auto-clear in the same cycle.
- Lockup: when a channel is active and Q==0, LOCK[c] sets (sticky). Writing STATUS with bit c=1 clears LOCK[c]. A set in the same cycle as a clear means set wins. Shifting continues regardless.
- Reads: when R=1, RD and RV=1 are presented the next cycle with the register value as of the R cycle (pre-update). RV is low otherwise, and RD holds its last value.
- R and W may be asserted together. A read of a register being written returns the old value.
- Width: POLY/DATA writes take D[N-1:0]. COUNT takes D[31:0]. CTRL takes D[1:0]. Reads zero-extend to 64.
- Channels are fully independent; no shared arbitration.
- Reset asserted mid-burst aborts immediately. After release everything stays stopped until software writes CTRL.

Test Plan:
- Step: N=32, ch0 POLY=0x80200003, DATA=0x1, CTRL=01 -> Q=0x3 one cycle later; done[0] pulses once; CTRL reads 0; busy[0] drops.
- Burst: ch1 same POLY, DATA=0x1, COUNT=3, CTRL=11 -> Q sequence 0x3, 0x6, 0xD; COUNT reads 0; done[1] pulses on the third shift; other channels unchanged.
- Continuous plus collision: ch2 CTRL=10 running; write DATA=0xABCD1234 -> next read returns 0xABCD1234, with shifting resuming the following cycle; CTRL=00 freezes Q.
- Lockup: ch3 DATA=0, CTRL=10 -> STATUS bit 3 = 1; write STATUS=0x8 while still zero -> bit remains 1 (set wins); DATA=1, then clear -> bit 0.
- Reads: read 0x0000-0x0008 and unmapped 0x00FF -> RD=0, RV high exactly one cycle after each R; back-to-back R on consecutive cycles gives consecutive RV.
- Async reset: drop reset mid-burst (COUNT=100) without a clock edge -> all outputs 0 immediately; after release, Q=0, CTRL=0, no shifting.
